// File: rtl/wishbone_dev_classic_if.sv
// Wishbone Classic (B4, non-pipelined) bus bundle shared by controller and device.
// Clock and reset travel with the bus so the device sees them as wb.clk_i / wb.rst_i.
interface wishbone_classic #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input logic clk_i,
  input logic rst_i
);

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;

  modport device (
    input  clk_i,
    input  rst_i,
    input  cyc_i,
    input  stb_i,
    input  we_i,
    input  adr_i,
    input  sel_i,
    input  dat_i,
    output dat_o,
    output ack_o,
    output err_o
  );

  modport controller (
    input  clk_i,
    input  rst_i,
    output cyc_i,
    output stb_i,
    output we_i,
    output adr_i,
    output sel_i,
    output dat_i,
    input  dat_o,
    input  ack_o,
    input  err_o
  );

endinterface

// File: rtl/wishbone_dev_classic.sv
// Wishbone Classic device adapter: one write/read strobe per bus transfer, registered ack/data.
// Optional checks: define WB_DEV_CLASSIC_ASSERT_EN to compile assertions and covers.
module wishbone_dev_classic #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  wishbone_classic.device         wb,
  input  logic                    ack,
  input  logic [DATA_WIDTH-1:0]   read_data,
  output logic                    request,
  output logic                    read_request,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [SEL_WIDTH-1:0]    byte_sel
);

  logic                  ack_reg;
  logic [DATA_WIDTH-1:0] dat_reg;
  logic                  active;
  logic                  accept;

  // Masking with ack_reg closes the transfer the cycle after accept, so a held stb
  // cannot strobe twice for the same bus transfer.
  assign active = wb.cyc_i & wb.stb_i & ~ack_reg & ~wb.rst_i;
  assign accept = active & ack;

  assign request      = accept & wb.we_i;
  assign read_request = accept & ~wb.we_i;

  assign write_data = wb.dat_i;
  assign address    = wb.adr_i;
  assign byte_sel   = wb.sel_i;

  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
    end else begin
      ack_reg <= accept;
      if (read_request) begin
        dat_reg <= read_data;
      end
    end
  end

  assign wb.ack_o = ack_reg;
  assign wb.dat_o = dat_reg;
  assign wb.err_o = 1'b0;

`ifdef WB_DEV_CLASSIC_ASSERT_EN
  default clocking cb @(posedge wb.clk_i);
  endclocking

  default disable iff (wb.rst_i);

  // Last accepted write value, used only to qualify the isolated-write cover.
  logic [DATA_WIDTH-1:0] last_write_reg;

  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      last_write_reg <= '0;
    end else if (request) begin
      last_write_reg <= write_data;
    end
  end

  a_ack_needs_cyc: assert property (wb.ack_o |-> $past(wb.cyc_i));

  a_no_back_to_back_ack: assert property (wb.ack_o |=> !wb.ack_o);

  a_strobes_exclusive: assert property (!(request && read_request));

  a_strobe_then_ack: assert property ((request || read_request) |=> wb.ack_o);

  c_isolated_write: cover property (
    (!request && !read_request)[*10]
    ##1 (request && (write_data != last_write_reg))
    ##1 (!request && !read_request)[*10]
  );
`endif

endmodule

// File: tb/tb_wishbone_dev_classic.sv
// Directed bench: stimulus pushes expected strobe/ack events; a negedge monitor pops and checks them.
module tb_wishbone_dev_classic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b1;
  logic [31:0] read_data = '0;
  logic        request;
  logic        read_request;
  logic [31:0] write_data;
  logic [31:0] address;
  logic [3:0]  byte_sel;

  int total = 0;
  int bad   = 0;
  int cnum  = 0;

  typedef struct {
    byte         kind;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] exp_dat;

  always #5 clk = ~clk;
  always @(posedge clk) cnum <= cnum + 1;

  wishbone_classic #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wb (.clk_i(clk), .rst_i(rst));

  wishbone_dev_classic #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .wb           (wb.device),
    .ack          (ack),
    .read_data    (read_data),
    .request      (request),
    .read_request (read_request),
    .write_data   (write_data),
    .address      (address),
    .byte_sel     (byte_sel)
  );

  task automatic push(input byte kind, input int cyc, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input byte kind, input logic [31:0] data);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s cycle=%0d got data=%h required none", kind, cnum, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cnum || e.data !== data) begin
        bad++;
        $display("FAIL event got %s cycle=%0d data=%h required %s cycle=%0d data=%h",
                 kind, cnum, data, e.kind, e.cyc, e.data);
      end else begin
        $display("txn %s cycle=%0d data=%h ok", kind, cnum, data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (request === 1'b1)      check_evt("W", write_data);
      if (read_request === 1'b1) check_evt("R", address);
      if (wb.ack_o === 1'b1)     check_evt("A", wb.dat_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got %h required %h", name, got, req);
    end else begin
      $display("txn %s value=%h ok", name, got);
    end
  endtask

  task automatic idle();
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
  endtask

  initial begin
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = 1'b1;
    wb.adr_i = 32'h0;
    wb.sel_i = 4'hF;
    wb.dat_i = 32'hDEAD_BEEF;
    exp_dat  = '0;

    // Reset held two cycles with a live bus cycle.
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_ack_o", {31'b0, wb.ack_o}, 32'h0);
      check_val("rst_dat_o", wb.dat_o, 32'h0);
      check_val("rst_request", {31'b0, request}, 32'h0);
      check_val("rst_read_request", {31'b0, read_request}, 32'h0);
    end
    idle();
    rst = 1'b0;
    step();
    check_val("err_o", {31'b0, wb.err_o}, 32'h0);

    // Zero-wait write.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1;
    wb.adr_i = 32'h10; wb.dat_i = 32'hA5; ack = 1'b1;
    push("W", cnum, 32'hA5);
    push("A", cnum + 1, exp_dat);
    step();
    idle();
    step();
    step();

    // Zero-wait read; the read address is carried in the R event.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0;
    wb.adr_i = 32'h24; read_data = 32'h1234;
    exp_dat = 32'h1234;
    push("R", cnum, 32'h24);
    push("A", cnum + 1, exp_dat);
    step();
    read_data = 32'h9999;
    idle();
    step();
    step();

    // Write with three wait cycles.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1;
    wb.adr_i = 32'h30; wb.dat_i = 32'h77; ack = 1'b0;
    push("W", cnum + 3, 32'h77);
    push("A", cnum + 4, exp_dat);
    step();
    step();
    step();
    ack = 1'b1;
    step();
    idle();
    step();
    step();

    // Abort while stalled: stb dropped before the peripheral is ready.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; ack = 1'b0;
    step();
    wb.stb_i = 1'b0;
    step();
    ack = 1'b1;
    idle();
    step();
    step();

    // Burst with stb held six cycles; dat_i changes every cycle.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb.dat_i = 32'h100 + i;
      if (i % 2 == 0) begin
        push("W", cnum, 32'h100 + i);
        push("A", cnum + 1, exp_dat);
      end
      step();
    end
    idle();
    step();
    step();

    // Reset during a wait state cancels the transfer and clears dat_o.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; ack = 1'b0;
    step();
    rst = 1'b1; ack = 1'b1;
    step();
    check_val("midrst_read_request", {31'b0, read_request}, 32'h0);
    check_val("midrst_dat_o", wb.dat_o, 32'h0);
    rst = 1'b0;
    idle();
    exp_dat = '0;
    step();
    step();

    // Write after reset: its ack must present the cleared read data.
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1;
    wb.adr_i = 32'h40; wb.dat_i = 32'h5A5A; ack = 1'b1;
    push("W", cnum, 32'h5A5A);
    push("A", cnum + 1, exp_dat);
    step();
    idle();
    step();
    step();
    step();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got %0d left required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wishbone_dev_classic.md
# wishbone_dev_classic

Generic Wishbone Classic (B4, non-pipelined) device-side adapter. It turns bus cycles from a `wishbone_classic` interface (device modport) into single-cycle write/read strobes for a simple peripheral register block, such as the LED controller. It owns `ack_o`/`dat_o` generation and hides handshake timing from the peripheral. The peripheral supplies a readiness input (`ack`) and read data, and receives a one-cycle `request` pulse with the write data.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `dat_i`/`dat_o`/`write_data`/`read_data`.
- `ADDR_WIDTH`, 32, width of `adr_i`/`address`.
- `SEL_WIDTH`, `DATA_WIDTH/8`, byte-select width.

Ports (bus signals are carried in `wb`, modport `device`; listed flattened):
- `wb.clk_i`  in  1  single clock; all logic on rising edge.
- `wb.rst_i`  in  1  reset, synchronous, active-high.
- `wb.cyc_i`, `wb.stb_i`, `wb.we_i`  in  1 each  bus cycle, strobe, write enable.
- `wb.adr_i`  in  ADDR_WIDTH  address.
- `wb.sel_i`  in  SEL_WIDTH  byte selects.
- `wb.dat_i`  in  DATA_WIDTH  write data from controller.
- `wb.dat_o`  out  DATA_WIDTH  registered read data.
- `wb.ack_o`  out  1  registered acknowledge.
- `wb.err_o`  out  1  constant 0.
- `ack`  in  1  peripheral ready. Tie to 1 for zero-wait peripherals.
- `read_data`  in  DATA_WIDTH  peripheral read value.
- `request`  out  1  one-cycle write strobe.
- `read_request`  out  1  one-cycle read strobe.
- `write_data`  out  DATA_WIDTH  equals `wb.dat_i`.
- `address`  out  ADDR_WIDTH  equals `wb.adr_i`.
- `byte_sel`  out  SEL_WIDTH  equals `wb.sel_i`.

## Operation
- `active = cyc_i & stb_i & ~ack_o & ~rst_i`.
- `accept = active & ack`. Combinational; true in exactly one cycle per transfer.
- `request = accept & we_i`. `read_request = accept & ~we_i`. The two are mutually exclusive.
- Peripheral samples `write_data`/`address`/`byte_sel` on the rising edge where `request` is high.
- At that edge: `ack_o <= 1`; `dat_o <= read_data` for reads, otherwise `dat_o` holds.
- In every other non-reset cycle `ack_o <= 0`. `ack_o` is never high two consecutive cycles.
- Wait states: while `ack`=0 with `active`=1, no strobe and no `ack_o`; stall indefinitely.
- Abort: `cyc_i` or `stb_i` dropping before `accept` means no strobe and no `ack_o`.
- `ack_o` already registered when `cyc_i` drops in the same cycle: the ack is still emitted (bus ignores it). The next transfer is unaffected.
- `err_o` is always 0. No retry support.

## Timing
- Reset (`rst_i`=1 at edge): `ack_o`=0, `dat_o`=0.
- During reset `request`=0 and `read_request`=0 (combinationally gated).
- Reset mid-wait or mid-accept cancels the transfer; no `ack_o` follows.
- Latency with `ack`=1: `stb_i` rises in cycle N; strobe in N; `ack_o` in N+1.
- Back-to-back with `stb_i` held: strobes N, N+2, N+4…; acks N+1, N+3… (one transfer per 2 clocks).
- With `ack` low for k cycles: strobe and `ack_o` are each delayed by k.
- `dat_o` is valid in the `ack_o` cycle and stable until the next read accept or reset.

## Configuration
- `WB_DEV_CLASSIC_ASSERT_EN` defined: compile in concurrent assertions and covers. Default clocking `posedge clk_i`; `disable iff (rst_i)`. Asserts:
  - `ack_o` implies `cyc_i` was high in the prior cycle.
  - No `ack_o` in consecutive cycles.
  - `request` and `read_request` are never both high.
  - Each strobe is followed by `ack_o` in the next cycle unless reset.
- Cover: 10 idle cycles, then a write strobe whose `write_data` differs from the prior write, then 10 idle cycles.
- Macro undefined: no verification constructs. Functional RTL identical.

## Test plan
- Reset: `rst_i`=1 for 2 cycles with `cyc_i`=`stb_i`=1 -> `ack_o`=0, `dat_o`=0, `request`=0 throughout.
- Write, `ack`=1: `cyc`=`stb`=`we`=1, `dat_i`=0xA5 in cycle N -> `request`=1 in N only, `write_data`=0xA5, `ack_o`=1 in N+1 only.
- Read: `we`=0, `read_data`=0x1234 -> `read_request`=1 in N, `ack_o`=1 and `dat_o`=0x1234 in N+1, `request` stays 0.
- Wait: `ack`=0 for 3 cycles then 1 -> strobe in N+3, `ack_o` in N+4 only.
- Abort: `stb_i` dropped after 1 cycle while `ack`=0 -> no strobe, no `ack_o`.
- Burst: `stb_i` held for 6 cycles, `ack`=1 -> strobes in N, N+2, N+4; `ack_o` in N+1, N+3, N+5.
